booth_mult_seq: RTL and testbench

- Sequential radix-4 Booth multiplier: signed WIDTH x WIDTH operands, 2*WIDTH signed product.
- Steps the multiplier through 3-bit overlapping Booth windows, one per clock, and accumulates shifted, recoded multiples of the multiplicand.
- Sits in the FFT butterfly datapath between the twiddle/sample operand registers and the butterfly adder stage.
- Provides the start/busy/done control the single-step Booth cells lack.

---
 rtl/booth_mult_seq.sv | 96 +++++++++
 tb/tb_booth_mult_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one 3-bit window per clock, STEPS clocks per product.
// start/flush/busy/done control wraps the recoding datapath for the FFT butterfly.
module booth_mult_seq #(
   parameter int WIDTH = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               flush,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int STEPS = WIDTH / 2;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [2*WIDTH-1:0] a_q, acc, mult, addend, acc_sum;
   logic [WIDTH:0]     b_q;
   logic [CW-1:0]      cnt;
   logic               accept, last;

   assign accept = start && !flush && (state == IDLE || state == DONE);
   assign last   = (state == RUN) && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // b_q shifts right two bits per step, so the live window is always b_q[2:0]
   always_comb begin
      mult = '0;
      case (b_q[2:0])
         3'b001, 3'b010: mult = a_q;
         3'b011:         mult = a_q << 1;
         3'b100:         mult = -(a_q << 1);
         3'b101, 3'b110: mult = -a_q;
         default:        mult = '0;
      endcase
   end

   assign addend  = mult << {cnt, 1'b0};
   assign acc_sum = acc + addend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (flush) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         a_q <= {{WIDTH{mcand[WIDTH-1]}}, mcand};
         b_q <= {mplier, 1'b0};
         acc <= '0;
         cnt <= '0;
      end else if (state == RUN) begin
         acc <= acc_sum;
         b_q <= b_q >> 2;
         cnt <= cnt + 1'b1;
         if (last) product <= acc_sum;
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: cycle-level timing/product model checked every cycle,
// plus literal expectations for each vector.
module tb_booth_mult_seq;

   localparam int WIDTH = 12;
   localparam int STEPS = WIDTH / 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic                     flush = 1'b0;
   logic signed [WIDTH-1:0]  mcand = '0;
   logic signed [WIDTH-1:0]  mplier = '0;
   logic                     busy, done;
   logic [2*WIDTH-1:0]       product;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   booth_mult_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
      .mcand(mcand), .mplier(mplier),
      .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an accepted start yields done exactly STEPS edges later with the true signed product
   logic                      m_busy = 1'b0, m_done = 1'b0;
   logic signed [2*WIDTH-1:0] m_prod = '0, m_pend = '0;
   int                        m_rem = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_prod <= '0; m_pend <= '0; m_rem <= 0;
      end else if (flush) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0;
      end else if (m_busy) begin
         m_rem <= m_rem - 1;
         if (m_rem == 1) begin
            m_busy <= 1'b0; m_done <= 1'b1; m_prod <= m_pend;
         end
      end else begin
         m_done <= 1'b0;
         if (start) begin
            m_busy <= 1'b1;
            m_rem  <= STEPS;
            m_pend <= mcand * mplier;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {31'd0, busy}, {31'd0, m_busy});
         chk("done", {31'd0, done}, {31'd0, m_done});
         chk("product", {8'd0, product}, {8'd0, m_prod});
      end
   end

   task automatic go(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
      @(posedge clk); #2;
      start = 1'b1; mcand = a; mplier = b;
      @(posedge clk); #2;
      start = 1'b0; mcand = WIDTH'($urandom); mplier = WIDTH'($urandom);
   endtask

   task automatic wait_done(input string name, input logic [2*WIDTH-1:0] exp, input int exp_n);
      int n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, n, exp_n);
      chk({name, "_product"}, {8'd0, product}, {8'd0, exp});
   endtask

   initial begin
      int ndone;
      @(posedge clk);
      chk_en = 1'b1;
      @(posedge clk); #2;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_product", {8'd0, product}, 32'd0);
      rst_n = 1'b1;

      go(12'sd3, 12'sd5);         wait_done("3x5", 24'h00000F, STEPS + 1);
      go(-12'sd7, 12'sd9);        wait_done("m7x9", 24'hFFFFC1, STEPS + 1);
      go(12'sd9, -12'sd7);        wait_done("9xm7", 24'hFFFFC1, STEPS + 1);
      go(-12'sd2048, -12'sd2048); wait_done("min_min", 24'h400000, STEPS + 1);
      go(12'sd2047, -12'sd2048);  wait_done("max_min", 24'hC00800, STEPS + 1);
      go(12'sd0, -12'sd1);        wait_done("0xm1", 24'h000000, STEPS + 1);

      // start while busy must be ignored
      go(12'sd3, 12'sd5);
      @(posedge clk); #2; start = 1'b1; mcand = 12'sd100; mplier = 12'sd100;
      @(posedge clk); #2; start = 1'b0;
      wait_done("busy_ignore", 24'h00000F, STEPS - 1);
      ndone = 0;
      repeat (10) begin @(negedge clk); if (done) ndone++; end
      chk("busy_ignore_single_done", ndone, 0);

      // back-to-back: start held during the DONE cycle
      go(12'sd3, 12'sd5);
      wait_done("b2b_first", 24'h00000F, STEPS + 1);
      start = 1'b1; mcand = -12'sd1; mplier = -12'sd1;
      @(posedge clk); #2; start = 1'b0;
      wait_done("b2b_second", 24'h000001, STEPS + 1);

      // flush during the third step
      go(12'sd3, 12'sd5);
      @(posedge clk); #2;
      @(posedge clk); #2; flush = 1'b1;
      @(posedge clk); #2; flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      ndone = 0;
      repeat (10) begin @(negedge clk); if (done) ndone++; end
      chk("flush_no_done", ndone, 0);
      chk("flush_product_kept", {8'd0, product}, 32'd1);

      // asynchronous reset between edges
      go(12'sd5, 12'sd7);
      @(posedge clk); #3; rst_n = 1'b0; #1;
      chk("areset_busy", {31'd0, busy}, 32'd0);
      chk("areset_done", {31'd0, done}, 32'd0);
      chk("areset_product", {8'd0, product}, 32'd0);
      @(posedge clk); #2; rst_n = 1'b1;
      go(12'sd6, -12'sd6);        wait_done("6xm6", 24'hFFFFDC, STEPS + 1);

      repeat (3) @(posedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
